palette_sequencer: RTL and testbench

PALETTE_SEQUENCER -- requirements
Module: palette_sequencer

---
 rtl/palette_sequencer.sv | 167 ++++++++++++++++
 tb/tb_palette_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/palette_sequencer.sv
// rtl/palette_sequencer.sv - palette switch sequencer with colour-id rotation and fade.
// Define PALETTE_FADE_EN for fade-out/fade-in palette changes; otherwise changes land on the next frame.
module palette_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [7:0] cfg_data,
  input  logic [2:0] cid_in,
  output logic [2:0] cid_out,
  output logic [1:0] pid,
  input  logic [5:0] color_in,
  output logic [5:0] color_out,
  output logic       busy
);

  typedef enum logic [1:0] {RUN, FADE_OUT, FADE_IN, PEND} state_e;

  state_e     state_q, state_d;
  logic [1:0] pid_q, pid_d, pend_q, pend_d;
  logic [2:0] rot_q, rot_d;
  logic [3:0] rcnt_q, rcnt_d, cper_q, cper_d;
  logic [5:0] color_q, color_d;
  logic [1:0] opc;
  logic       accept;
  logic       unused_cfg;

  assign opc        = cfg_data[7:6];
  assign accept     = cfg_valid && (state_q == RUN);
  assign unused_cfg = ^cfg_data[5:4];

  assign cfg_ready = (state_q == RUN);
  assign busy      = (state_q != RUN);
  assign pid       = pid_q;
  assign color_out = color_q;

  // Rotation maps ids 1..7 onto themselves; id 0 (transparent) is never rotated.
  logic [3:0] csum;
  logic [2:0] cmod;
  assign csum    = {1'b0, cid_in} + {1'b0, rot_q} - 4'd1;
  assign cmod    = (csum >= 4'd7) ? 3'(csum - 4'd7) : csum[2:0];
  assign cid_out = (cid_in == 3'd0) ? 3'd0 : cmod + 3'd1;

  always_comb begin
    rot_d  = rot_q;
    rcnt_d = rcnt_q;
    cper_d = cper_q;
    if (frame_start && cper_q != 4'd0) begin
      if (rcnt_q >= cper_q - 4'd1) begin
        rcnt_d = 4'd0;
        rot_d  = (rot_q == 3'd6) ? 3'd0 : rot_q + 3'd1;
      end else begin
        rcnt_d = rcnt_q + 4'd1;
      end
    end
    if (accept && opc == 2'b01) begin
      cper_d = cfg_data[3:0];
      if (cfg_data[3:0] == 4'd0) rcnt_d = 4'd0;
    end
    if (accept && opc == 2'b11 && cfg_data[0]) rot_d = 3'd0;
  end

`ifdef PALETTE_FADE_EN
  logic [1:0] lvl_q, lvl_d;
  logic [3:0] fcnt_q, fcnt_d, fper_q, fper_d, fcnt_inc;
  logic       fexp;

  assign fcnt_inc = fcnt_q + 4'd1;
  assign fexp     = (fcnt_inc == fper_q);

  function automatic logic [1:0] sat_sub(input logic [1:0] c, input logic [1:0] l);
    return (c > l) ? c - l : 2'd0;
  endfunction

  assign color_d = {sat_sub(color_in[5:4], lvl_q), sat_sub(color_in[3:2], lvl_q),
                    sat_sub(color_in[1:0], lvl_q)};
`else
  assign color_d = color_in;
`endif

  always_comb begin
    state_d = state_q;
    pid_d   = pid_q;
    pend_d  = pend_q;
`ifdef PALETTE_FADE_EN
    lvl_d   = lvl_q;
    fcnt_d  = fcnt_q;
    fper_d  = fper_q;
    if (accept && opc == 2'b10) fper_d = (cfg_data[3:0] == 4'd0) ? 4'd1 : cfg_data[3:0];
`endif
    case (state_q)
      RUN: begin
        if (accept && opc == 2'b00) begin
          pend_d = cfg_data[1:0];
`ifdef PALETTE_FADE_EN
          state_d = FADE_OUT;
          fcnt_d  = 4'd0;
`else
          state_d = PEND;
`endif
        end
      end
`ifdef PALETTE_FADE_EN
      FADE_OUT: begin
        if (frame_start) begin
          fcnt_d = fexp ? 4'd0 : fcnt_inc;
          if (fexp && lvl_q == 2'd3) begin
            pid_d   = pend_q;
            state_d = FADE_IN;
          end else if (fexp) begin
            lvl_d = lvl_q + 2'd1;
          end
        end
      end
      FADE_IN: begin
        if (frame_start) begin
          fcnt_d = fexp ? 4'd0 : fcnt_inc;
          if (fexp) begin
            lvl_d = lvl_q - 2'd1;
            if (lvl_q == 2'd1) state_d = RUN;
          end
        end
      end
`else
      PEND: begin
        if (frame_start) begin
          pid_d   = pend_q;
          state_d = RUN;
        end
      end
`endif
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pid_q   <= 2'd0;
      pend_q  <= 2'd0;
      rot_q   <= 3'd0;
      rcnt_q  <= 4'd0;
      cper_q  <= 4'd0;
      color_q <= 6'd0;
`ifdef PALETTE_FADE_EN
      lvl_q   <= 2'd0;
      fcnt_q  <= 4'd0;
      fper_q  <= 4'd1;
`endif
    end else begin
      state_q <= state_d;
      pid_q   <= pid_d;
      pend_q  <= pend_d;
      rot_q   <= rot_d;
      rcnt_q  <= rcnt_d;
      cper_q  <= cper_d;
      color_q <= color_d;
`ifdef PALETTE_FADE_EN
      lvl_q   <= lvl_d;
      fcnt_q  <= fcnt_d;
      fper_q  <= fper_d;
`endif
    end
  end

endmodule

// File: tb/tb_palette_sequencer.sv
// tb/tb_palette_sequencer.sv - directed scoreboard bench for palette_sequencer.
module tb_palette_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       frame_start = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [7:0] cfg_data = 8'd0;
  logic [2:0] cid_in = 3'd0;
  logic [2:0] cid_out;
  logic [1:0] pid;
  logic [5:0] color_in = 6'd0;
  logic [5:0] color_out;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [5:0] exp_color_q[$];

  palette_sequencer dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_data(cfg_data), .cid_in(cid_in), .cid_out(cid_out),
    .pid(pid), .color_in(color_in), .color_out(color_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_cid(input logic [2:0] c, input int r);
    if (c == 3'd0) return 3'd0;
    return 3'(((int'(c) - 1 + r) % 7) + 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    int k = 0;
    cfg_valid = 1'b1;
    cfg_data  = d;
    while (!cfg_ready && k < 50) begin
      tick();
      k++;
    end
    chk("send_ready", 8'(cfg_ready), 8'd1);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic color_step(input string tag, input logic [5:0] c, input logic [5:0] e);
    logic [5:0] popped;
    color_in = c;
    exp_color_q.push_back(e);
    tick();
    if (exp_color_q.size() == 0) begin
      chk({tag, "_empty"}, 8'd0, 8'd1);
    end else begin
      popped = exp_color_q.pop_front();
      chk(tag, 8'(color_out), 8'(popped));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pid"}, 8'(pid), 8'd0);
    chk({tag, "_busy"}, 8'(busy), 8'd0);
    chk({tag, "_ready"}, 8'(cfg_ready), 8'd1);
    chk({tag, "_color"}, 8'(color_out), 8'd0);
  endtask

  initial begin
    logic [5:0] rc;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    color_step("color_full", 6'h3F, 6'h3F);
    chk("pid_after_reset", 8'(pid), 8'd0);
    chk("ready_after_reset", 8'(cfg_ready), 8'd1);
    for (int i = 0; i < 3; i++) begin
      rc = 6'($urandom_range(0, 63));
      color_step("color_pass", rc, rc);
    end

    send(8'h41);
    cid_in = 3'd7;
    #1 chk("cid_rot0", 8'(cid_out), 8'(exp_cid(3'd7, 0)));
    for (int f = 1; f <= 3; f++) begin
      frame();
      chk("cid_rot_step", 8'(cid_out), 8'(exp_cid(3'd7, f)));
    end
    chk("cid_after3", 8'(cid_out), 8'd3);
    for (int c = 0; c < 8; c++) begin
      cid_in = 3'(c);
      #1 chk("cid_table_rot3", 8'(cid_out), 8'(exp_cid(3'(c), 3)));
    end
    cid_in = 3'd7;
    send(8'h40);
    frame();
    chk("cid_frozen", 8'(cid_out), 8'(exp_cid(3'd7, 3)));
    send(8'h42);
    frame();
    chk("cid_p2_hold", 8'(cid_out), 8'(exp_cid(3'd7, 3)));
    frame();
    chk("cid_p2_wrap", 8'(cid_out), 8'(exp_cid(3'd7, 4)));
    send(8'h40);
    send(8'hC1);
    chk("cid_rot_clear", 8'(cid_out), 8'd7);

`ifdef PALETTE_FADE_EN
    begin
      logic [5:0] fade_col [7] = '{6'h2A, 6'h15, 6'h00, 6'h00, 6'h15, 6'h2A, 6'h3F};
      send(8'h81);
      color_in = 6'h3F;
      send(8'h02);
      chk("fade_busy_start", 8'(busy), 8'd1);
      chk("fade_ready_start", 8'(cfg_ready), 8'd0);
      chk("fade_pid_start", 8'(pid), 8'd0);
      cfg_valid = 1'b1;
      cfg_data  = 8'h01;
      for (int f = 0; f < 7; f++) begin
        frame();
        chk("fade_pid", 8'(pid), (f >= 3) ? 8'd2 : 8'd0);
        if (f == 6) begin
          chk("fade_end_busy", 8'(busy), 8'd0);
          chk("fade_end_ready", 8'(cfg_ready), 8'd1);
        end
        color_step("fade_color", 6'h3F, fade_col[f]);
        chk("held_busy", 8'(busy), 8'd1);
        chk("held_ready", 8'(cfg_ready), 8'd0);
      end
      cfg_valid = 1'b0;
      for (int f = 0; f < 5; f++) frame();
      chk("fadein_pid1", 8'(pid), 8'd1);
      chk("fadein_busy", 8'(busy), 8'd1);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("reset_fadein");
      @(posedge clk);
      #1 rst_n = 1'b1;
      color_step("color_after_reset", 6'h3F, 6'h3F);
    end
`else
    send(8'h80);
    chk("op10_busy", 8'(busy), 8'd0);
    chk("op10_ready", 8'(cfg_ready), 8'd1);
    send(8'h41);
    cfg_valid   = 1'b1;
    cfg_data    = 8'h03;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    cfg_data    = 8'h01;
    chk("pend_pid_hold", 8'(pid), 8'd0);
    chk("pend_busy", 8'(busy), 8'd1);
    chk("pend_ready", 8'(cfg_ready), 8'd0);
    chk("pend_cid_rot1", 8'(cid_out), 8'(exp_cid(3'd7, 1)));
    repeat (2) tick();
    chk("pend_pid_still0", 8'(pid), 8'd0);
    chk("pend_busy_still", 8'(busy), 8'd1);
    color_step("pend_color", 6'h2D, 6'h2D);
    frame();
    chk("pend_pid3", 8'(pid), 8'd3);
    chk("pend_done_busy", 8'(busy), 8'd0);
    chk("pend_done_ready", 8'(cfg_ready), 8'd1);
    chk("pend_cid_rot2", 8'(cid_out), 8'(exp_cid(3'd7, 2)));
    tick();
    chk("held_accept_busy", 8'(busy), 8'd1);
    chk("held_accept_ready", 8'(cfg_ready), 8'd0);
    cfg_valid = 1'b0;
    frame();
    chk("pend_pid1", 8'(pid), 8'd1);
    chk("pend_pid1_busy", 8'(busy), 8'd0);
    send(8'h02);
    chk("pend2_busy", 8'(busy), 8'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_pend");
    chk("reset_cid", 8'(cid_out), 8'd7);
    @(posedge clk);
    #1 rst_n = 1'b1;
    color_step("color_after_reset", 6'h3F, 6'h3F);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
